io_channel_fifo: RTL and testbench

IO_CHANNEL_FIFO -- requirements
Module: io_channel_fifo

---
 rtl/io_channel_fifo.sv | 177 +++++++++++++++++
 tb/tb_io_channel_fifo.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_channel_fifo.sv
// Two single-clock word channels between a host and the CPU core:
// an input channel popped by "in" and an output channel filled by "out".
module io_channel_fifo #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn = 8,
    parameter int NOut = 8,
    parameter int OutWrap = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          inPush,
    input  logic [MemoryElementWidth-1:0] inData,
    output logic                          inFull,
    input  logic                          cpuIn,
    output logic [MemoryElementWidth-1:0] cpuInData,
    output logic                          cpuInValid,
    output logic [$clog2(NIn+1)-1:0]      inSize,
    input  logic                          cpuOut,
    input  logic [MemoryElementWidth-1:0] cpuOutData,
    input  logic                          outPop,
    output logic [MemoryElementWidth-1:0] outData,
    output logic                          outEmpty,
    output logic [$clog2(NOut+1)-1:0]     outCount,
    output logic                          inUnderflow,
    output logic                          outOverflow,
    input  logic                          clearErr
);

    localparam int W   = MemoryElementWidth;
    localparam int IAW = $clog2(NIn);
    localparam int ICW = $clog2(NIn+1);
    localparam int OAW = $clog2(NOut);
    localparam int OCW = $clog2(NOut+1);

    localparam logic [IAW-1:0] IN_LAST   = IAW'(NIn-1);
    localparam logic [ICW-1:0] IN_DEPTH  = ICW'(NIn);
    localparam logic [OAW-1:0] OUT_LAST  = OAW'(NOut-1);
    localparam logic [OCW-1:0] OUT_DEPTH = OCW'(NOut);
    localparam logic           WRAP_EN   = (OutWrap != 0);

    logic [W-1:0]   r_in_mem [NIn];
    logic [IAW-1:0] r_in_wr;
    logic [IAW-1:0] r_in_rd;
    logic [ICW-1:0] r_in_cnt;
    logic [W-1:0]   r_cpu_data;
    logic           r_cpu_valid;
    logic           r_underflow;

    logic [W-1:0]   r_out_mem [NOut];
    logic [OAW-1:0] r_out_wr;
    logic [OAW-1:0] r_out_rd;
    logic [OCW-1:0] r_out_cnt;
    logic           r_overflow;

    logic w_in_full;
    logic w_in_empty;
    logic w_in_push;
    logic w_in_pop;
    logic w_out_full;
    logic w_out_empty;
    logic w_out_pop;
    logic w_out_ovf;
    logic w_out_write;
    logic w_out_rd_adv;

    function automatic logic [IAW-1:0] in_next(input logic [IAW-1:0] p);
        return (p == IN_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [OAW-1:0] out_next(input logic [OAW-1:0] p);
        return (p == OUT_LAST) ? '0 : p + 1'b1;
    endfunction

    // Input channel handshake decode; the pop sees only pre-edge contents
    assign w_in_full  = (r_in_cnt == IN_DEPTH);
    assign w_in_empty = (r_in_cnt == '0);
    assign w_in_push  = inPush & ~w_in_full;
    assign w_in_pop   = cpuIn & ~w_in_empty;

    // Output channel decode; a write into a full channel either rides on a
    // same-cycle pop, overwrites the oldest word, or is dropped
    assign w_out_full   = (r_out_cnt == OUT_DEPTH);
    assign w_out_empty  = (r_out_cnt == '0);
    assign w_out_pop    = outPop & ~w_out_empty;
    assign w_out_ovf    = cpuOut & w_out_full & ~w_out_pop;
    assign w_out_write  = cpuOut & (~w_out_full | w_out_pop | WRAP_EN);
    assign w_out_rd_adv = w_out_pop | (w_out_ovf & WRAP_EN);

    assign inFull      = w_in_full;
    assign inSize      = r_in_cnt;
    assign cpuInData   = r_cpu_data;
    assign cpuInValid  = r_cpu_valid;
    assign inUnderflow = r_underflow;
    assign outEmpty    = w_out_empty;
    assign outCount    = r_out_cnt;
    assign outData     = r_out_mem[r_out_rd];
    assign outOverflow = r_overflow;

    // Input channel storage, no reset needed
    always_ff @(posedge clock) begin
        if (w_in_push) begin
            r_in_mem[r_in_wr] <= inData;
        end
    end

    // Input channel pointers, occupancy and CPU-side pop register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_wr     <= '0;
            r_in_rd     <= '0;
            r_in_cnt    <= '0;
            r_cpu_data  <= '0;
            r_cpu_valid <= 1'b0;
        end else begin
            r_cpu_valid <= w_in_pop;
            if (w_in_push) begin
                r_in_wr <= in_next(r_in_wr);
            end
            if (w_in_pop) begin
                r_cpu_data <= r_in_mem[r_in_rd];
                r_in_rd    <= in_next(r_in_rd);
            end
            if (w_in_push && !w_in_pop) begin
                r_in_cnt <= r_in_cnt + ICW'(1);
            end else if (!w_in_push && w_in_pop) begin
                r_in_cnt <= r_in_cnt - ICW'(1);
            end
        end
    end

    // Output channel storage, no reset needed
    always_ff @(posedge clock) begin
        if (w_out_write) begin
            r_out_mem[r_out_wr] <= cpuOutData;
        end
    end

    // Output channel pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_write) begin
                r_out_wr <= out_next(r_out_wr);
            end
            if (w_out_rd_adv) begin
                r_out_rd <= out_next(r_out_rd);
            end
            if (w_out_write && !w_out_rd_adv) begin
                r_out_cnt <= r_out_cnt + OCW'(1);
            end else if (!w_out_write && w_out_rd_adv) begin
                r_out_cnt <= r_out_cnt - OCW'(1);
            end
        end
    end

    // Sticky error flags; clearErr wins over a same-cycle set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clearErr) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (cpuIn && w_in_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_out_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_channel_fifo.sv
// Bench for io_channel_fifo: directed vector table, corner-case
// sequences, then random traffic against a queue-based model.
module tb_io_channel_fifo;

    localparam int W = 12;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         inPush = 1'b0;
    logic [W-1:0] inData = '0;
    logic         cpuIn = 1'b0;
    logic         cpuOut = 1'b0;
    logic [W-1:0] cpuOutData = '0;
    logic         outPop = 1'b0;
    logic         clearErr = 1'b0;

    logic         inFull0, inFull1;
    logic [W-1:0] cpuInData0, cpuInData1;
    logic         cpuInValid0, cpuInValid1;
    logic [3:0]   inSize0, inSize1;
    logic [W-1:0] outData0, outData1;
    logic         outEmpty0, outEmpty1;
    logic [3:0]   outCount0, outCount1;
    logic         inUnderflow0, inUnderflow1;
    logic         outOverflow0, outOverflow1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    io_channel_fifo #(.MemoryElementWidth(W), .NIn(8), .NOut(8), .OutWrap(0)) u0 (
        .clock(clock), .reset(reset), .inPush(inPush), .inData(inData),
        .inFull(inFull0), .cpuIn(cpuIn), .cpuInData(cpuInData0),
        .cpuInValid(cpuInValid0), .inSize(inSize0), .cpuOut(cpuOut),
        .cpuOutData(cpuOutData), .outPop(outPop), .outData(outData0),
        .outEmpty(outEmpty0), .outCount(outCount0),
        .inUnderflow(inUnderflow0), .outOverflow(outOverflow0),
        .clearErr(clearErr)
    );

    io_channel_fifo #(.MemoryElementWidth(W), .NIn(8), .NOut(8), .OutWrap(1)) u1 (
        .clock(clock), .reset(reset), .inPush(inPush), .inData(inData),
        .inFull(inFull1), .cpuIn(cpuIn), .cpuInData(cpuInData1),
        .cpuInValid(cpuInValid1), .inSize(inSize1), .cpuOut(cpuOut),
        .cpuOutData(cpuOutData), .outPop(outPop), .outData(outData1),
        .outEmpty(outEmpty1), .outCount(outCount1),
        .inUnderflow(inUnderflow1), .outOverflow(outOverflow1),
        .clearErr(clearErr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        inPush = 0; cpuIn = 0; cpuOut = 0; outPop = 0; clearErr = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    typedef struct {
        int push; int idat; int cin; int cout; int odat; int opop; int clr;
        int e_size; int e_val; int e_data; int e_unf; int e_ocnt; int e_odat;
    } vec_t;

    vec_t tbl[13];

    // Reference model state
    int qin[$];
    int qo0[$];
    int qo1[$];
    int m_data, m_val, m_unf, m_ovf0, m_ovf1;

    task automatic model_reset();
        qin.delete(); qo0.delete(); qo1.delete();
        m_data = 0; m_val = 0; m_unf = 0; m_ovf0 = 0; m_ovf1 = 0;
    endtask

    task automatic model_out(inout int q[$], inout int ovf, input int wrap);
        bit full, pop_ok;
        full = (q.size() == 8);
        pop_ok = outPop && q.size() > 0;
        if (pop_ok) void'(q.pop_front());
        if (cpuOut) begin
            if (!full || pop_ok) begin
                q.push_back(int'(cpuOutData));
            end else begin
                ovf = 1;
                if (wrap != 0) begin
                    void'(q.pop_front());
                    q.push_back(int'(cpuOutData));
                end
            end
        end
        if (clearErr) ovf = 0;
    endtask

    task automatic model_step();
        int n;
        n = qin.size();
        m_val = 0;
        if (cpuIn && n > 0) begin
            m_data = qin.pop_front();
            m_val = 1;
        end
        if (cpuIn && n == 0) m_unf = 1;
        if (clearErr) m_unf = 0;
        if (inPush && n < 8) qin.push_back(int'(inData));
        model_out(qo0, m_ovf0, 0);
        model_out(qo1, m_ovf1, 1);
    endtask

    task automatic model_compare();
        chk("r_inSize", inSize0, qin.size());
        chk("r_inFull", inFull0, qin.size() == 8);
        chk("r_valid", cpuInValid0, m_val);
        chk("r_data", cpuInData0, m_data);
        chk("r_unf", inUnderflow0, m_unf);
        chk("r_ocnt0", outCount0, qo0.size());
        chk("r_oemp0", outEmpty0, qo0.size() == 0);
        chk("r_ovf0", outOverflow0, m_ovf0);
        chk("r_ocnt1", outCount1, qo1.size());
        chk("r_ovf1", outOverflow1, m_ovf1);
        if (qo0.size() > 0) chk("r_odat0", outData0, qo0[0]);
        if (qo1.size() > 0) chk("r_odat1", outData1, qo1[0]);
    endtask

    initial begin
        // push,idat,cin,cout,odat,opop,clr, size,val,data,unf,ocnt,odat
        tbl[0]  = '{1, 88, 0, 0, 0, 0, 0,  1, 0,  0, 0, 0, 0};
        tbl[1]  = '{1, 44, 0, 0, 0, 0, 0,  2, 0,  0, 0, 0, 0};
        tbl[2]  = '{0,  0, 1, 0, 0, 0, 0,  1, 1, 88, 0, 0, 0};
        tbl[3]  = '{0,  0, 1, 0, 0, 0, 0,  0, 1, 44, 0, 0, 0};
        tbl[4]  = '{0,  0, 1, 0, 0, 0, 0,  0, 0, 44, 1, 0, 0};
        tbl[5]  = '{0,  0, 0, 0, 0, 0, 1,  0, 0, 44, 0, 0, 0};
        tbl[6]  = '{0,  0, 1, 0, 0, 0, 1,  0, 0, 44, 0, 0, 0};
        tbl[7]  = '{1,  5, 1, 0, 0, 0, 0,  1, 0, 44, 1, 0, 0};
        tbl[8]  = '{1,  6, 1, 0, 0, 0, 0,  1, 1,  5, 1, 0, 0};
        tbl[9]  = '{0,  0, 0, 1, 7, 0, 0,  1, 0,  5, 1, 1, 7};
        tbl[10] = '{0,  0, 0, 1, 8, 1, 0,  1, 0,  5, 1, 1, 8};
        tbl[11] = '{0,  0, 0, 0, 0, 1, 0,  1, 0,  5, 1, 0, 0};
        tbl[12] = '{0,  0, 0, 1, 9, 1, 0,  1, 0,  5, 1, 1, 9};

        // Reset state
        reset = 1;
        #3;
        chk("rst_inSize", inSize0, 0);
        chk("rst_inFull", inFull0, 0);
        chk("rst_outCount", outCount0, 0);
        chk("rst_outEmpty", outEmpty0, 1);
        chk("rst_valid", cpuInValid0, 0);
        chk("rst_data", cpuInData0, 0);
        chk("rst_flags", {inUnderflow0, outOverflow0}, 0);
        @(negedge clock);
        reset = 0;

        // Vector table
        for (int i = 0; i < 13; i++) begin
            inPush = 1'(tbl[i].push);
            inData = W'(tbl[i].idat);
            cpuIn = 1'(tbl[i].cin);
            cpuOut = 1'(tbl[i].cout);
            cpuOutData = W'(tbl[i].odat);
            outPop = 1'(tbl[i].opop);
            clearErr = 1'(tbl[i].clr);
            step();
            chk($sformatf("v%0d_inSize", i), inSize0, tbl[i].e_size);
            chk($sformatf("v%0d_valid", i), cpuInValid0, tbl[i].e_val);
            chk($sformatf("v%0d_data", i), cpuInData0, tbl[i].e_data);
            chk($sformatf("v%0d_unf", i), inUnderflow0, tbl[i].e_unf);
            chk($sformatf("v%0d_ocnt", i), outCount0, tbl[i].e_ocnt);
            chk($sformatf("v%0d_ovf", i), outOverflow0, 0);
            if (tbl[i].e_ocnt > 0)
                chk($sformatf("v%0d_odat", i), outData0, tbl[i].e_odat);
        end

        // Input channel fill past full, then drain
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            inPush = 1; inData = W'(k);
            step();
            if (k == 7) chk("in_notfull7", inFull0, 0);
            if (k >= 8) chk($sformatf("in_full%0d", k), inFull0, 1);
        end
        inPush = 0;
        chk("in_size8", inSize0, 8);
        for (int k = 1; k <= 8; k++) begin
            cpuIn = 1;
            step();
            chk($sformatf("in_pop%0d", k), cpuInData0, k);
        end
        cpuIn = 0;
        chk("in_drained", inSize0, 0);

        // Full input push ignored even with same-cycle pop
        for (int k = 1; k <= 8; k++) begin
            inPush = 1; inData = W'(20 + k);
            step();
        end
        cpuIn = 1; inData = W'(99);
        step();
        inPush = 0;
        chk("in_fullpp_size", inSize0, 7);
        chk("in_fullpp_data", cpuInData0, 21);
        for (int k = 2; k <= 8; k++) begin
            step();
            chk($sformatf("in_fullpp_pop%0d", k), cpuInData0, 20 + k);
        end
        cpuIn = 0;

        // Output channel overflow, drop vs overwrite
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            cpuOut = 1; cpuOutData = W'(k);
            step();
        end
        cpuOut = 0;
        chk("ow0_cnt", outCount0, 8);
        chk("ow0_ovf", outOverflow0, 1);
        chk("ow1_cnt", outCount1, 8);
        chk("ow1_ovf", outOverflow1, 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ow0_drain%0d", k), outData0, k + 1);
            chk($sformatf("ow1_drain%0d", k), outData1, k + 2);
            outPop = 1;
            step();
        end
        outPop = 0;
        chk("ow0_empty", outEmpty0, 1);
        chk("ow1_empty", outEmpty1, 1);

        // Full output channel: write and pop together
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            cpuOut = 1; cpuOutData = W'(k);
            step();
        end
        cpuOut = 1; cpuOutData = W'(9); outPop = 1;
        step();
        cpuOut = 0;
        outPop = 0;
        chk("wp_cnt0", outCount0, 8);
        chk("wp_ovf0", outOverflow0, 0);
        chk("wp_cnt1", outCount1, 8);
        chk("wp_ovf1", outOverflow1, 0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("wp_drain%0d", k), outData0, k + 2);
            outPop = 1;
            step();
        end
        outPop = 0;
        chk("wp_empty", outEmpty0, 1);

        // Asynchronous reset mid-operation
        do_reset();
        cpuIn = 1;
        step();
        cpuIn = 0;
        for (int k = 1; k <= 3; k++) begin
            inPush = 1; inData = W'(k);
            cpuOut = 1; cpuOutData = W'(k);
            step();
        end
        idle();
        chk("ar_pre_in", inSize0, 3);
        chk("ar_pre_out", outCount0, 3);
        chk("ar_pre_unf", inUnderflow0, 1);
        @(negedge clock);
        #1;
        reset = 1;
        #1;
        chk("ar_inSize", inSize0, 0);
        chk("ar_outCount", outCount0, 0);
        chk("ar_outEmpty", outEmpty0, 1);
        chk("ar_flags", {inUnderflow0, outOverflow0}, 0);
        chk("ar_valid", cpuInValid0, 0);
        #1;
        reset = 0;

        // Random traffic against the model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            int bias;
            bias = ((c / 150) % 2 == 0) ? 70 : 30;
            inPush = ($urandom_range(99) < bias);
            inData = W'($urandom);
            cpuIn = ($urandom_range(99) < 100 - bias);
            cpuOut = ($urandom_range(99) < bias);
            cpuOutData = W'($urandom);
            outPop = ($urandom_range(99) < 100 - bias);
            clearErr = ($urandom_range(99) < 4);
            model_step();
            step();
            model_compare();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
